// File: rtl/multicore_sobel_cpu_top_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit frames with a single output slot and
// an end-of-trace drain sequence that reports test_ending / test_has_ended.
module multicore_sobel_cpu_top_oci_dct_packer #(
    parameter int MAX_ATOMS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        end_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        test_ending,
    output logic        test_has_ended
);

    typedef enum logic [1:0] {FILL, HOLD, ENDING, ENDED} state_t;

    state_t      state_q, state_d;
    logic [29:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        endSeen_q, endSeen_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  count_q, count_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        slotFree;
    logic        closeFrame;
    logic [29:0] accAfter;
    logic [3:0]  cntAfter;

    assign atom_ready     = (state_q == FILL) && !endSeen_q && !reset;
    assign accept         = atom_valid && atom_ready;
    assign slotFree       = !valid_q || dct_ready;
    assign dct_buffer     = buf_q;
    assign dct_count      = count_q;
    assign dct_valid      = valid_q;
    assign test_ending    = (state_q == ENDING) && !reset;
    assign test_has_ended = (state_q == ENDED) && !reset;

    // Accumulator contents as they would be after this cycle's accept; bits
    // above the fill point stay zero because acc is cleared on every transfer.
    always_comb begin
        accAfter = acc_q;
        if (accept) begin
            accAfter[{cnt_q, 1'b0} +: 2] = atom_data;
        end
        cntAfter = cnt_q + {3'b000, accept};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        endSeen_d  = endSeen_q | end_req;
        buf_d      = buf_q;
        count_d    = count_q;
        valid_d    = valid_q && !dct_ready;
        closeFrame = 1'b0;

        case (state_q)
            FILL: begin
                // A pending end request behaves like a flush of whatever is buffered.
                closeFrame = (accept && (cntAfter == 4'(MAX_ATOMS)))
                          || ((flush || endSeen_d) && (cntAfter != 4'd0));
                acc_d = accAfter;
                cnt_d = cntAfter;
                if (closeFrame) begin
                    if (slotFree) begin
                        buf_d   = accAfter;
                        count_d = cntAfter;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (endSeen_q && (cnt_q == 4'd0) && !valid_q) begin
                    state_d = ENDING;
                end
            end
            HOLD: begin
                if (slotFree) begin
                    buf_d   = acc_q;
                    count_d = cnt_q;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            ENDING: state_d = ENDED;
            ENDED:  state_d = ENDED;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            acc_q     <= '0;
            cnt_q     <= '0;
            endSeen_q <= 1'b0;
            buf_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            endSeen_q <= endSeen_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_multicore_sobel_cpu_top_oci_dct_packer.sv
// Directed-vector bench for the DCT atom packer: framing, flush, backpressure,
// end-of-trace sequencing and reset discard.
module tb_multicore_sobel_cpu_top_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        atom_ready;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_ending;
    logic        test_has_ended;

    int assertCount = 0;
    int failCount   = 0;

    multicore_sobel_cpu_top_oci_dct_packer #(.MAX_ATOMS(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendAtom(input logic [1:0] d);
        atom_valid = 1'b1;
        atom_data  = d;
        tick();
        atom_valid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        atom_valid = 1'b0; flush = 1'b0; end_req = 1'b0; dct_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        atom_valid = 1'b0; atom_data = 2'd0; flush = 1'b0; end_req = 1'b0; dct_ready = 1'b0;
        tick();
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: valid=%b count=%0d buf=%h, required 0/0/0", dct_valid, dct_count, dct_buffer);
        end
        assertCount++;
        if (atom_ready !== 1'b0 || test_ending !== 1'b0 || test_has_ended !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags: ready=%b ending=%b ended=%b, required 0/0/0", atom_ready, test_ending, test_has_ended);
        end
        reset = 1'b0;
        #1;
        assertCount++;
        if (atom_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ready_after_reset: got %b, required 1", atom_ready);
        end
    endtask

    task automatic test_full_frame();
        logic [29:0] expBuf;
        expBuf = '0;
        for (int k = 0; k < 15; k++) expBuf[2*k +: 2] = 2'(k % 4);
        dct_ready = 1'b1;
        for (int k = 0; k < 14; k++) sendAtom(2'(k % 4));
        assertCount++;
        if (dct_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_early_valid: got %b, required 0", dct_valid);
        end
        sendAtom(2'd2);
        assertCount++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== expBuf) begin
            failCount++;
            $display("[TB] FAIL full_frame: valid=%b count=%0d buf=%h, required 1/15/%h", dct_valid, dct_count, dct_buffer, expBuf);
        end
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || dct_count !== 4'd15 || dct_buffer !== expBuf) begin
            failCount++;
            $display("[TB] FAIL full_consumed: valid=%b count=%0d buf=%h, required 0/15/%h", dct_valid, dct_count, dct_buffer, expBuf);
        end
        tick();
        assertCount++;
        if (dct_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_single_frame: valid=%b, required 0", dct_valid);
        end
    endtask

    task automatic test_flush();
        dct_ready = 1'b1;
        sendAtom(2'd3);
        sendAtom(2'd2);
        sendAtom(2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        assertCount++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h0000001B) begin
            failCount++;
            $display("[TB] FAIL flush_frame: valid=%b count=%0d buf=%h, required 1/3/0000001b", dct_valid, dct_count, dct_buffer);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || dct_count !== 4'd3) begin
            failCount++;
            $display("[TB] FAIL flush_empty: valid=%b count=%0d, required 0/3", dct_valid, dct_count);
        end
    endtask

    task automatic test_backpressure();
        doReset();
        dct_ready = 1'b0;
        for (int k = 0; k < 15; k++) sendAtom(2'd1);
        assertCount++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h15555555) begin
            failCount++;
            $display("[TB] FAIL bp_first: valid=%b buf=%h, required 1/15555555", dct_valid, dct_buffer);
        end
        for (int k = 0; k < 15; k++) sendAtom(2'd2);
        assertCount++;
        if (atom_ready !== 1'b0 || dct_buffer !== 30'h15555555 || dct_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL bp_hold: ready=%b valid=%b buf=%h, required 0/1/15555555", atom_ready, dct_valid, dct_buffer);
        end
        atom_valid = 1'b1; atom_data = 2'd3; flush = 1'b1;
        tick();
        atom_valid = 1'b0; flush = 1'b0;
        assertCount++;
        if (atom_ready !== 1'b0 || dct_buffer !== 30'h15555555) begin
            failCount++;
            $display("[TB] FAIL bp_hold_stable: ready=%b buf=%h, required 0/15555555", atom_ready, dct_buffer);
        end
        dct_ready = 1'b1;
        tick();
        assertCount++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA || atom_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL bp_second: valid=%b count=%0d buf=%h ready=%b, required 1/15/2aaaaaaa/1", dct_valid, dct_count, dct_buffer, atom_ready);
        end
        tick();
        assertCount++;
        if (dct_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_drained: valid=%b, required 0", dct_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        assertCount++;
        if (dct_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_no_extra: valid=%b, required 0", dct_valid);
        end
    endtask

    task automatic test_end();
        doReset();
        dct_ready = 1'b0;
        sendAtom(2'd0); sendAtom(2'd1); sendAtom(2'd2); sendAtom(2'd3); sendAtom(2'd0);
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        assertCount++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd5 || dct_buffer !== 30'h000000E4 || atom_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL end_frame: valid=%b count=%0d buf=%h ready=%b, required 1/5/000000e4/0", dct_valid, dct_count, dct_buffer, atom_ready);
        end
        dct_ready = 1'b1;
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || test_ending !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL end_consumed: valid=%b ending=%b, required 0/0", dct_valid, test_ending);
        end
        tick();
        assertCount++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL end_pulse: ending=%b ended=%b, required 1/0", test_ending, test_has_ended);
        end
        atom_valid = 1'b1; atom_data = 2'd3; flush = 1'b1; end_req = 1'b1;
        tick();
        assertCount++;
        if (test_ending !== 1'b0 || test_has_ended !== 1'b1 || atom_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL end_ended: ending=%b ended=%b ready=%b, required 0/1/0", test_ending, test_has_ended, atom_ready);
        end
        tick();
        tick();
        atom_valid = 1'b0; flush = 1'b0; end_req = 1'b0;
        assertCount++;
        if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || dct_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL end_sticky: ended=%b ending=%b valid=%b, required 1/0/0", test_has_ended, test_ending, dct_valid);
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        dct_ready = 1'b1;
        atom_valid = 1'b1; atom_data = 2'd2; flush = 1'b1; end_req = 1'b1;
        tick();
        atom_valid = 1'b0; flush = 1'b0; end_req = 1'b0;
        assertCount++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'h00000002) begin
            failCount++;
            $display("[TB] FAIL simul_frame: valid=%b count=%0d buf=%h, required 1/1/00000002", dct_valid, dct_count, dct_buffer);
        end
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || test_ending !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL simul_drain: valid=%b ending=%b, required 0/0", dct_valid, test_ending);
        end
        tick();
        assertCount++;
        if (test_ending !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL simul_pulse: ending=%b, required 1", test_ending);
        end
        tick();
        assertCount++;
        if (test_ending !== 1'b0 || test_has_ended !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL simul_ended: ending=%b ended=%b, required 0/1", test_ending, test_has_ended);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        dct_ready = 1'b0;
        for (int k = 0; k < 15; k++) sendAtom(2'd3);
        for (int k = 0; k < 7; k++) sendAtom(2'd1);
        assertCount++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h3FFFFFFF) begin
            failCount++;
            $display("[TB] FAIL mid_setup: valid=%b buf=%h, required 1/3fffffff", dct_valid, dct_buffer);
        end
        reset = 1'b1;
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0 || atom_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_reset: valid=%b count=%0d buf=%h ready=%b, required 0/0/0/0", dct_valid, dct_count, dct_buffer, atom_ready);
        end
        reset = 1'b0;
        #1;
        assertCount++;
        if (atom_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mid_ready: ready=%b, required 1", atom_ready);
        end
        dct_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        assertCount++;
        if (dct_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0) begin
            failCount++;
            $display("[TB] FAIL mid_no_frame: valid=%b count=%0d buf=%h, required 0/0/0", dct_valid, dct_count, dct_buffer);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_end();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
